imem_loader: RTL

- Byte-stream program loader: the write side of the instruction memory.
- Receives a framed image over a valid/ready byte interface, assembles little-endian 32-bit words and drives the imem write port.
- Holds the CPU in reset until a complete image with a matching checksum is loaded.
- Sits between the host link (UART RX FIFO) and imem.

---
 rtl/imem_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory: LEN/DATA/CHK frame parsing,
// little-endian word assembly, imem write strobes and CPU reset release on a good image.
module imem_loader #(
  parameter logic [31:0] BASE_PC     = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] words_loaded,
  output logic        cpu_rst_n
);

  typedef enum logic [2:0] {StIdle, StLen, StData, StChk, StDone, StErr} state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] len_q, len_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  acc_q, acc_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] words_loaded_q, words_loaded_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        xfer;
  logic [31:0] len_full;
  logic [31:0] word_full;

  assign xfer      = rx_valid && busy_q;
  // Shifting in from the top leaves the first byte in bits 7:0 after four bytes.
  assign len_full  = {rx_data, len_q[31:8]};
  assign word_full = {rx_data, word_q[31:8]};

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    len_d          = len_q;
    idx_d          = idx_q;
    word_d         = word_q;
    acc_d          = acc_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    words_loaded_d = words_loaded_q;
    err_code_d     = err_code_q;

    case (state_q)
      StIdle: begin
        byte_cnt_d     = 2'd0;
        idx_d          = 32'd0;
        acc_d          = 8'd0;
        len_d          = 32'd0;
        words_loaded_d = 32'd0;
        err_code_d     = 2'd0;
        if (start) state_d = StLen;
      end
      StLen: begin
        if (xfer) begin
          len_d      = len_full;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (len_full > DEPTH_WORDS) begin
              state_d    = StErr;
              err_code_d = 2'd1;
            end else if (len_full == 32'd0) begin
              state_d = StChk;
            end else begin
              state_d = StData;
            end
          end
        end
      end
      StData: begin
        if (xfer) begin
          word_d     = word_full;
          acc_d      = acc_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wr_en_d        = 1'b1;
            wr_data_d      = word_full;
            wr_addr_d      = BASE_PC + (idx_q << 2);
            words_loaded_d = words_loaded_q + 32'd1;
            idx_d          = idx_q + 32'd1;
            if (idx_q + 32'd1 == len_q) state_d = StChk;
          end
        end
      end
      StChk: begin
        if (xfer) begin
          if (rx_data == acc_q) begin
            state_d = StDone;
          end else begin
            state_d    = StErr;
            err_code_d = 2'd2;
          end
        end
      end
      StDone, StErr: begin
        if (start) begin
          state_d        = StIdle;
          words_loaded_d = 32'd0;
          err_code_d     = 2'd0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Status flags are registered copies of the next state.
    busy_d = (state_d == StLen) || (state_d == StData) || (state_d == StChk);
    done_d = (state_d == StDone);
    err_d  = (state_d == StErr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      byte_cnt_q     <= 2'd0;
      len_q          <= 32'd0;
      idx_q          <= 32'd0;
      word_q         <= 32'd0;
      acc_q          <= 8'd0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= 32'd0;
      wr_data_q      <= 32'd0;
      words_loaded_q <= 32'd0;
      err_code_q     <= 2'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      len_q          <= len_d;
      idx_q          <= idx_d;
      word_q         <= word_d;
      acc_q          <= acc_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      words_loaded_q <= words_loaded_d;
      err_code_q     <= err_code_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign rx_ready     = busy_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign cpu_rst_n    = done_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign err_code     = err_code_q;
  assign words_loaded = words_loaded_q;

endmodule
